// File: rtl/atm_pkg.sv
`default_nettype none
// ============================================================================
// atm_pkg : op codes, response status codes and controller state encoding
// Revision: 1.0
// ============================================================================
package atm_pkg;

    localparam logic [2:0] OP_LOGIN    = 3'd0;
    localparam logic [2:0] OP_LOGOUT   = 3'd1;
    localparam logic [2:0] OP_BALANCE  = 3'd2;
    localparam logic [2:0] OP_WITHDRAW = 3'd3;
    localparam logic [2:0] OP_DEPOSIT  = 3'd4;
    localparam logic [2:0] OP_TRANSFER = 3'd5;

    typedef enum logic [3:0] {
        ST_OK          = 4'd0,
        ST_BAD_AUTH    = 4'd1,
        ST_LOCKED      = 4'd2,
        ST_NO_SESSION  = 4'd3,
        ST_INSUF_FUNDS = 4'd4,
        ST_BAD_DEST    = 4'd5,
        ST_OVERFLOW    = 4'd6,
        ST_TIMEOUT     = 4'd7,
        ST_ILLEGAL     = 4'd8
    } status_e;

    typedef enum logic [1:0] {
        S_WAIT_CMD = 2'd0,
        S_SCAN     = 2'd1,
        S_EXEC     = 2'd2,
        S_RESP     = 2'd3
    } state_e;

    // Ops that need the account table searched before execution
    function automatic logic is_scan_op(input logic [2:0] op);
        return (op == OP_LOGIN) || (op == OP_TRANSFER);
    endfunction

endpackage
`default_nettype wire

// File: rtl/atm_acct_scan.sv
`default_nettype none
// ============================================================================
// atm_acct_scan : walks the account table one entry per cycle, matching a
//                 source and a destination account number in the same pass
// Revision: 1.0
// ============================================================================
module atm_acct_scan #(
    parameter int NUM   = 10,
    parameter int ACC_W = 12,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [ACC_W-1:0] src_acc_i,
    input  logic [ACC_W-1:0] dst_acc_i,
    input  logic [ACC_W-1:0] entry_acc_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             done_o,
    output logic             src_found_o,
    output logic [IDX_W-1:0] src_idx_o,
    output logic             dst_found_o,
    output logic [IDX_W-1:0] dst_idx_o
);

    logic             busy_q;
    logic [IDX_W-1:0] idx_q;
    logic             src_found_q, dst_found_q;
    logic [IDX_W-1:0] src_idx_q, dst_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= 1'b0;
            idx_q       <= '0;
            src_found_q <= 1'b0;
            dst_found_q <= 1'b0;
            src_idx_q   <= '0;
            dst_idx_q   <= '0;
        end else if (start_i) begin
            busy_q      <= 1'b1;
            idx_q       <= '0;
            src_found_q <= 1'b0;
            dst_found_q <= 1'b0;
            src_idx_q   <= '0;
            dst_idx_q   <= '0;
        end else if (busy_q) begin
            // First hit is kept, so the lowest matching index wins
            if (!src_found_q && (entry_acc_i == src_acc_i)) begin
                src_found_q <= 1'b1;
                src_idx_q   <= idx_q;
            end
            if (!dst_found_q && (entry_acc_i == dst_acc_i)) begin
                dst_found_q <= 1'b1;
                dst_idx_q   <= idx_q;
            end
            if (idx_q == IDX_W'(NUM - 1)) begin
                busy_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign idx_o       = idx_q;
    assign done_o      = busy_q && (idx_q == IDX_W'(NUM - 1));
    assign src_found_o = src_found_q;
    assign src_idx_o   = src_idx_q;
    assign dst_found_o = dst_found_q;
    assign dst_idx_o   = dst_idx_q;

endmodule
`default_nettype wire

// File: rtl/atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// atm_session_ctrl : ATM account table, session, PIN lockout and transfers
// Revision: 1.0
// ============================================================================
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int NUM_ACCOUNTS = 10,
    parameter int ACC_W        = 12,
    parameter int PIN_W        = 4,
    parameter int BAL_W        = 16,
    parameter int AMT_W        = 11,
    parameter int ACC_BASE     = 2000,
    parameter int INIT_BAL     = 500,
    parameter int MAX_TRIES    = 3,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [2:0]                      cmd_op,
    input  logic [ACC_W-1:0]                cmd_acc,
    input  logic [PIN_W-1:0]                cmd_pin,
    input  logic [ACC_W-1:0]                cmd_dest,
    input  logic [AMT_W-1:0]                cmd_amount,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_ACCOUNTS)-1:0] cfg_idx,
    input  logic [ACC_W-1:0]                cfg_acc,
    input  logic [PIN_W-1:0]                cfg_pin,
    input  logic [BAL_W-1:0]                cfg_bal,
    output logic                            rsp_valid,
    output logic [3:0]                      rsp_status,
    output logic [BAL_W-1:0]                rsp_balance,
    output logic                            session_active,
    output logic [NUM_ACCOUNTS-1:0]         locked_mask
);

    localparam int IDX_W  = $clog2(NUM_ACCOUNTS);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

    state_e state_q, state_d;

    logic [2:0]       op_q;
    logic [ACC_W-1:0] acc_l_q, dest_l_q;
    logic [PIN_W-1:0] pin_l_q;
    logic [AMT_W-1:0] amt_q;
    logic             sess_q;
    logic [IDX_W-1:0] sess_idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic             rsp_valid_q;
    status_e          rsp_status_q;
    logic [BAL_W-1:0] rsp_balance_q;

    logic [ACC_W-1:0]  acc_q  [NUM_ACCOUNTS];
    logic [PIN_W-1:0]  pin_q  [NUM_ACCOUNTS];
    logic [BAL_W-1:0]  bal_q  [NUM_ACCOUNTS];
    logic [FAIL_W-1:0] fail_q [NUM_ACCOUNTS];
    logic [NUM_ACCOUNTS-1:0] lock_q;

    logic             w_hs, w_tmo_fire, w_cfg_wr;
    logic [IDX_W-1:0] w_scan_idx, w_src_idx, w_dst_idx;
    logic             w_scan_done, w_src_found, w_dst_found;
    logic [ACC_W-1:0] w_entry_acc;

    assign w_hs       = cmd_valid && (state_q == S_WAIT_CMD);
    assign w_tmo_fire = (state_q == S_WAIT_CMD) && sess_q && !cmd_valid &&
                        (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign w_cfg_wr   = cfg_we && (state_q == S_WAIT_CMD) && !sess_q &&
                        (int'(cfg_idx) < NUM_ACCOUNTS);
    assign w_entry_acc = acc_q[w_scan_idx];

    atm_acct_scan #(
        .NUM   (NUM_ACCOUNTS),
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_scan (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_hs && is_scan_op(cmd_op)),
        .src_acc_i   (acc_l_q),
        .dst_acc_i   (dest_l_q),
        .entry_acc_i (w_entry_acc),
        .idx_o       (w_scan_idx),
        .done_o      (w_scan_done),
        .src_found_o (w_src_found),
        .src_idx_o   (w_src_idx),
        .dst_found_o (w_dst_found),
        .dst_idx_o   (w_dst_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT_CMD: begin
                if (w_hs)            state_d = is_scan_op(cmd_op) ? S_SCAN : S_EXEC;
                else if (w_tmo_fire) state_d = S_RESP;
            end
            S_SCAN:  if (w_scan_done) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  state_d = S_WAIT_CMD;
            default: state_d = S_WAIT_CMD;
        endcase
    end

    // Execution results, applied on the EXEC -> RESP edge
    status_e           x_status;
    logic              x_sess, x_src_we, x_dst_we, x_fail_we, x_lock_set;
    logic [IDX_W-1:0]  x_sess_idx;
    logic [BAL_W-1:0]  x_src_bal, x_dst_bal, x_rsp_bal;
    logic [FAIL_W-1:0] x_fail_val;
    logic [BAL_W-1:0]  w_amt, w_sess_bal, w_dst_cur;
    logic [BAL_W:0]    w_dep_sum, w_dst_sum;

    assign w_amt      = BAL_W'(amt_q);
    assign w_sess_bal = bal_q[sess_idx_q];
    assign w_dst_cur  = bal_q[w_dst_idx];
    assign w_dep_sum  = {1'b0, w_sess_bal} + {1'b0, w_amt};
    assign w_dst_sum  = {1'b0, w_dst_cur} + {1'b0, w_amt};

    always_comb begin
        x_status   = ST_OK;
        x_sess     = sess_q;
        x_sess_idx = sess_idx_q;
        x_src_we   = 1'b0;
        x_src_bal  = w_sess_bal;
        x_dst_we   = 1'b0;
        x_dst_bal  = w_dst_sum[BAL_W-1:0];
        x_fail_we  = 1'b0;
        x_fail_val = '0;
        x_lock_set = 1'b0;
        case (op_q)
            OP_LOGIN: begin
                x_sess = 1'b0;
                if (!w_src_found) begin
                    x_status = ST_BAD_AUTH;
                end else if (lock_q[w_src_idx]) begin
                    x_status = ST_LOCKED;
                end else if (pin_q[w_src_idx] != pin_l_q) begin
                    x_status   = ST_BAD_AUTH;
                    x_fail_we  = 1'b1;
                    x_fail_val = fail_q[w_src_idx] + FAIL_W'(1);
                    x_lock_set = (x_fail_val >= FAIL_W'(MAX_TRIES));
                end else begin
                    x_fail_we  = 1'b1;
                    x_sess     = 1'b1;
                    x_sess_idx = w_src_idx;
                end
            end
            OP_LOGOUT: begin
                if (!sess_q) x_status = ST_NO_SESSION;
                else         x_sess   = 1'b0;
            end
            OP_BALANCE: begin
                if (!sess_q) x_status = ST_NO_SESSION;
            end
            OP_WITHDRAW: begin
                if (!sess_q) begin
                    x_status = ST_NO_SESSION;
                end else if (w_amt > w_sess_bal) begin
                    x_status = ST_INSUF_FUNDS;
                end else begin
                    x_src_we  = 1'b1;
                    x_src_bal = w_sess_bal - w_amt;
                end
            end
            OP_DEPOSIT: begin
                if (!sess_q) begin
                    x_status = ST_NO_SESSION;
                end else if (w_dep_sum[BAL_W]) begin
                    x_status = ST_OVERFLOW;
                end else begin
                    x_src_we  = 1'b1;
                    x_src_bal = w_dep_sum[BAL_W-1:0];
                end
            end
            OP_TRANSFER: begin
                if (!sess_q) begin
                    x_status = ST_NO_SESSION;
                end else if (!w_dst_found || (w_dst_idx == sess_idx_q)) begin
                    x_status = ST_BAD_DEST;
                end else if (w_amt > w_sess_bal) begin
                    x_status = ST_INSUF_FUNDS;
                end else if (w_dst_sum[BAL_W]) begin
                    x_status = ST_OVERFLOW;
                end else begin
                    x_src_we  = 1'b1;
                    x_src_bal = w_sess_bal - w_amt;
                    x_dst_we  = 1'b1;
                end
            end
            default: x_status = ST_ILLEGAL;
        endcase
        if (!x_sess)       x_rsp_bal = '0;
        else if (x_src_we) x_rsp_bal = x_src_bal;
        else               x_rsp_bal = bal_q[x_sess_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_WAIT_CMD;
            op_q          <= '0;
            acc_l_q       <= '0;
            dest_l_q      <= '0;
            pin_l_q       <= '0;
            amt_q         <= '0;
            sess_q        <= 1'b0;
            sess_idx_q    <= '0;
            tmo_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= ST_OK;
            rsp_balance_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            if (w_hs) begin
                op_q     <= cmd_op;
                acc_l_q  <= cmd_acc;
                dest_l_q <= cmd_dest;
                pin_l_q  <= cmd_pin;
                amt_q    <= cmd_amount;
                tmo_q    <= '0;
            end else if (w_tmo_fire) begin
                sess_q        <= 1'b0;
                tmo_q         <= '0;
                rsp_valid_q   <= 1'b1;
                rsp_status_q  <= ST_TIMEOUT;
                rsp_balance_q <= '0;
            end else if ((state_q == S_WAIT_CMD) && sess_q) begin
                tmo_q <= tmo_q + 1'b1;
            end else if (!sess_q) begin
                tmo_q <= '0;
            end
            if (state_q == S_EXEC) begin
                sess_q        <= x_sess;
                sess_idx_q    <= x_sess_idx;
                rsp_valid_q   <= 1'b1;
                rsp_status_q  <= x_status;
                rsp_balance_q <= x_rsp_bal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                acc_q[i]  <= ACC_W'(ACC_BASE + i);
                pin_q[i]  <= PIN_W'(i);
                bal_q[i]  <= BAL_W'(INIT_BAL);
                fail_q[i] <= '0;
                lock_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                if (w_cfg_wr && (cfg_idx == IDX_W'(i))) begin
                    acc_q[i]  <= cfg_acc;
                    pin_q[i]  <= cfg_pin;
                    bal_q[i]  <= cfg_bal;
                    fail_q[i] <= '0;
                    lock_q[i] <= 1'b0;
                end
                if (state_q == S_EXEC) begin
                    if (x_src_we && (sess_idx_q == IDX_W'(i))) bal_q[i] <= x_src_bal;
                    if (x_dst_we && (w_dst_idx == IDX_W'(i)))  bal_q[i] <= x_dst_bal;
                    if (x_fail_we && (w_src_idx == IDX_W'(i))) begin
                        fail_q[i] <= x_fail_val;
                        if (x_lock_set) lock_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign cmd_ready      = (state_q == S_WAIT_CMD);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_status     = rsp_status_q;
    assign rsp_balance    = rsp_balance_q;
    assign session_active = sess_q;
    assign locked_mask    = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_atm_session_ctrl.sv
`default_nettype none
// ============================================================================
// tb_atm_session_ctrl : vector table plus response scoreboard for the ATM
//                       session controller
// Revision: 1.0
// ============================================================================
module tb_atm_session_ctrl;

    localparam int N = 10;
    localparam int TMO = 1000;
    localparam int S_OK = 0, S_BAD_AUTH = 1, S_LOCKED = 2, S_NO_SESSION = 3,
                   S_INSUF = 4, S_BAD_DEST = 5, S_OVERFLOW = 6, S_TIMEOUT = 7,
                   S_ILLEGAL = 8;
    localparam int O_LOGIN = 0, O_LOGOUT = 1, O_BALANCE = 2, O_WITHDRAW = 3,
                   O_DEPOSIT = 4, O_TRANSFER = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [11:0] cmd_acc = '0, cmd_dest = '0;
    logic [3:0]  cmd_pin = '0;
    logic [10:0] cmd_amount = '0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [11:0] cfg_acc = '0;
    logic [3:0]  cfg_pin = '0;
    logic [15:0] cfg_bal = '0;
    logic        rsp_valid;
    logic [3:0]  rsp_status;
    logic [15:0] rsp_balance;
    logic        session_active;
    logic [9:0]  locked_mask;

    atm_session_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_acc(cmd_acc), .cmd_pin(cmd_pin), .cmd_dest(cmd_dest),
        .cmd_amount(cmd_amount),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_acc(cfg_acc),
        .cfg_pin(cfg_pin), .cfg_bal(cfg_bal),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_balance(rsp_balance), .session_active(session_active),
        .locked_mask(locked_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_cfg;
        logic [2:0]  op;
        logic [11:0] acc;
        logic [3:0]  pin;
        logic [11:0] dest;
        logic [10:0] amt;
        logic [3:0]  idx;
        logic [15:0] bal;
        int          exp_st;
        int          exp_bal;
        int          exp_sess;
        int          exp_lock;
    } vec_t;

    typedef struct {
        int st;
        int bal;
        int t0;
        int lo;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   last_rsp_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Scoreboard: every response pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: status %0d balance %0d with nothing outstanding",
                         rsp_status, rsp_balance);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_status", int'(rsp_status), e.st);
                chk("rsp_balance", int'(rsp_balance), e.bal);
                chk_range("rsp_latency", cyc - e.t0, e.lo, e.hi);
                last_rsp_cyc = cyc;
            end
        end
    end

    task automatic drain(input int limit, input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < limit) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL %s: no response within %0d cycles", name, limit);
            exp_q.delete();
        end
    endtask

    function automatic vec_t c(input int op, input int acc, input int pin, input int dest,
                               input int amt, input int st, input int bal, input int sess,
                               input int lock);
        vec_t v;
        v.is_cfg = 1'b0;
        v.op = 3'(op); v.acc = 12'(acc); v.pin = 4'(pin); v.dest = 12'(dest);
        v.amt = 11'(amt); v.idx = '0; v.bal = '0;
        v.exp_st = st; v.exp_bal = bal; v.exp_sess = sess; v.exp_lock = lock;
        return v;
    endfunction

    function automatic vec_t w(input int idx, input int acc, input int pin, input int bal,
                               input int lock);
        vec_t v;
        v = c(0, acc, pin, 0, 0, 0, 0, 0, lock);
        v.is_cfg = 1'b1;
        v.idx = 4'(idx);
        v.bal = 16'(bal);
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        int g;
        tag = $sformatf("vec%0d", n);
        @(negedge clk);
        if (v.is_cfg) begin
            cfg_we = 1'b1; cfg_idx = v.idx; cfg_acc = v.acc; cfg_pin = v.pin; cfg_bal = v.bal;
            @(negedge clk);
            cfg_we = 1'b0;
            @(negedge clk);
        end else begin
            g = 0;
            while (!cmd_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
            cmd_valid = 1'b1; cmd_op = v.op; cmd_acc = v.acc; cmd_pin = v.pin;
            cmd_dest = v.dest; cmd_amount = v.amt;
            begin
                exp_t e;
                int lat;
                lat = (v.op == 3'(O_LOGIN) || v.op == 3'(O_TRANSFER)) ? N + 2 : 2;
                e.st = v.exp_st; e.bal = v.exp_bal; e.t0 = cyc; e.lo = lat; e.hi = lat;
                exp_q.push_back(e);
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            drain(40, tag);
            chk({tag, "_session_active"}, int'(session_active), v.exp_sess);
        end
        chk({tag, "_locked_mask"}, int'(locked_mask), v.exp_lock);
    endtask

    vec_t vt1[$];
    vec_t vt2[$];

    initial begin
        vt1 = '{
            c(O_LOGIN,    2003, 3, 0,    0,    S_OK,         500,   1, 0),
            c(O_WITHDRAW, 0,    0, 0,    200,  S_OK,         300,   1, 0),
            c(O_WITHDRAW, 0,    0, 0,    400,  S_INSUF,      300,   1, 0),
            c(O_TRANSFER, 0,    0, 2007, 100,  S_OK,         200,   1, 0),
            c(O_TRANSFER, 0,    0, 2003, 100,  S_BAD_DEST,   200,   1, 0),
            c(O_TRANSFER, 0,    0, 2042, 100,  S_BAD_DEST,   200,   1, 0),
            c(O_LOGOUT,   0,    0, 0,    0,    S_OK,         0,     0, 0),
            c(O_LOGOUT,   0,    0, 0,    0,    S_NO_SESSION, 0,     0, 0),
            c(O_DEPOSIT,  0,    0, 0,    5,    S_NO_SESSION, 0,     0, 0),
            w(5, 2005, 5, 65500, 0),
            c(O_LOGIN,    2005, 5, 0,    0,    S_OK,         65500, 1, 0),
            c(O_DEPOSIT,  0,    0, 0,    100,  S_OVERFLOW,   65500, 1, 0),
            c(O_DEPOSIT,  0,    0, 0,    35,   S_OK,         65535, 1, 0),
            c(O_DEPOSIT,  0,    0, 0,    0,    S_OK,         65535, 1, 0),
            c(O_LOGIN,    2007, 7, 0,    0,    S_OK,         600,   1, 0),
            c(O_TRANSFER, 0,    0, 2005, 2000, S_INSUF,      600,   1, 0),
            c(O_TRANSFER, 0,    0, 2005, 100,  S_OVERFLOW,   600,   1, 0),
            c(O_LOGIN,    2001, 9, 0,    0,    S_BAD_AUTH,   0,     0, 0),
            c(O_LOGIN,    2001, 9, 0,    0,    S_BAD_AUTH,   0,     0, 0),
            c(O_LOGIN,    2001, 9, 0,    0,    S_BAD_AUTH,   0,     0, 2),
            c(O_LOGIN,    2001, 1, 0,    0,    S_LOCKED,     0,     0, 2),
            w(1, 2001, 1, 500, 0),
            c(O_LOGIN,    2001, 1, 0,    0,    S_OK,         500,   1, 0),
            c(7,          0,    0, 0,    50,   S_ILLEGAL,    500,   1, 0),
            c(O_BALANCE,  0,    0, 0,    0,    S_OK,         500,   1, 0),
            w(2, 2002, 2, 1, 0)
        };
        vt2 = '{
            c(O_BALANCE,  0,    0, 0,    0,    S_NO_SESSION, 0,     0, 0),
            c(6,          0,    0, 0,    0,    S_ILLEGAL,    0,     0, 0),
            c(O_LOGIN,    2002, 2, 0,    0,    S_OK,         500,   1, 0),
            c(O_LOGIN,    2042, 0, 0,    0,    S_BAD_AUTH,   0,     0, 0)
        };

        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_status", int'(rsp_status), 0);
        chk("reset_rsp_balance", int'(rsp_balance), 0);
        chk("reset_session", int'(session_active), 0);
        chk("reset_locked", int'(locked_mask), 0);

        foreach (vt1[i]) run_vec(vt1[i], i);

        // Idle with a session open: unsolicited TIMEOUT pulse
        begin
            exp_t e;
            e.st = S_TIMEOUT; e.bal = 0; e.t0 = last_rsp_cyc; e.lo = TMO; e.hi = TMO + 2;
            exp_q.push_back(e);
        end
        drain(TMO + 100, "timeout");
        @(negedge clk);
        chk("timeout_session", int'(session_active), 0);

        foreach (vt2[i]) run_vec(vt2[i], 100 + i);

        // Reset in the middle of a LOGIN scan must abort with no response
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'(O_LOGIN); cmd_acc = 12'd2003; cmd_pin = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midreset_session", int'(session_active), 0);
        chk("midreset_cmd_ready", int'(cmd_ready), 1);
        chk("midreset_rsp_balance", int'(rsp_balance), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
Clocked, parametrised ATM transaction controller: next generation of the teller block. Holds an account/PIN/balance table of NUM_ACCOUNTS entries with a valid/ready command port, a one-cycle response pulse, per-account PIN-retry lockout, a session inactivity timeout, and deposit and overflow-checked transfers. Sits between the front-panel/command sequencer and the display/status logic.

Parameters:
NUM_ACCOUNTS, 10, number of table entries
ACC_W, 12, account number width
PIN_W, 4, PIN width
BAL_W, 16, balance width
AMT_W, 11, transaction amount width (AMT_W <= BAL_W)
ACC_BASE, 2000, reset account number of entry i is ACC_BASE+i
INIT_BAL, 500, reset balance of every entry
MAX_TRIES, 3, consecutive wrong PINs before lock
TIMEOUT_CYC, 1000, idle cycles before session auto-ends

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept command
cmd_op  in  3  0 LOGIN, 1 LOGOUT, 2 BALANCE, 3 WITHDRAW, 4 DEPOSIT, 5 TRANSFER, 6-7 reserved
cmd_acc  in  ACC_W  account number (LOGIN)
cmd_pin  in  PIN_W  PIN (LOGIN)
cmd_dest  in  ACC_W  destination account (TRANSFER)
cmd_amount  in  AMT_W  amount
cfg_we  in  1  table write strobe
cfg_idx  in  clog2(NUM_ACCOUNTS)  entry index
cfg_acc / cfg_pin / cfg_bal  in  ACC_W / PIN_W / BAL_W  entry data
rsp_valid  out  1  one-cycle response pulse
rsp_status  out  4  0 OK, 1 BAD_AUTH, 2 LOCKED, 3 NO_SESSION, 4 INSUF_FUNDS, 5 BAD_DEST, 6 OVERFLOW, 7 TIMEOUT, 8 ILLEGAL
rsp_balance  out  BAL_W  session account balance after op, 0 if no session
session_active  out  1  a user is logged in
locked_mask  out  NUM_ACCOUNTS  per-entry lock flags

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Reset: state WAIT_CMD, cmd_ready=1, rsp_valid=0, rsp_status=0, rsp_balance=0, session_active=0, locked_mask=0, fail counters 0, timeout counter 0, entry i = {ACC_BASE+i, i[PIN_W-1:0], INIT_BAL}. Reset mid-operation aborts without response.
- FSM: WAIT_CMD -> (LOGIN/TRANSFER) SCAN -> EXEC -> RESP -> WAIT_CMD; other ops WAIT_CMD -> EXEC -> RESP. cmd_ready=1 only in WAIT_CMD; fields latched on cmd_valid&&cmd_ready.
- SCAN: exactly NUM_ACCOUNTS cycles, one entry per cycle, matching latched cmd_acc and cmd_dest in the same pass; lowest matching index wins. Fixed latency: accept at T, rsp_valid at T+NUM_ACCOUNTS+2 (scan ops) or T+2 (others).
- LOGIN: ends any current session first. Not found -> BAD_AUTH. Entry locked -> LOCKED (even with correct PIN, counter unchanged). Wrong PIN -> BAD_AUTH, counter+1; reaching MAX_TRIES sets lock bit. Correct PIN -> OK, counter cleared, session opened on that index.
- LOGOUT: OK and session closed; NO_SESSION if none.
- BALANCE/WITHDRAW/DEPOSIT/TRANSFER without session -> NO_SESSION, no change.
- WITHDRAW: amount <= bal -> subtract, OK; else INSUF_FUNDS.
- DEPOSIT: bal+amount computed BAL_W+1 bits; > 2^BAL_W-1 -> OVERFLOW, else add.
- TRANSFER: dest not found or dest == session index -> BAD_DEST; amount > src bal -> INSUF_FUNDS; dest+amount overflow -> OVERFLOW; else both updated in the same cycle. Check priority in that order.
- Amount 0 valid: OK, no change. Reserved op -> ILLEGAL, no change.
- Timeout: counter counts WAIT_CMD cycles with session_active and no handshake; cleared on any handshake. On reaching TIMEOUT_CYC the session closes and FSM enters RESP with TIMEOUT (unsolicited pulse). Handshake in the same cycle wins, no timeout.
- cfg_we honoured only in WAIT_CMD with session_active=0; otherwise dropped. Write clears that entry's lock and fail counter.

Decomposition:
- atm_pkg: op codes, status codes, FSM state enum, shared with the sequencer/display.
- Sub-module atm_acct_scan: sequential index counter plus source/destination comparators, producing found/index flags and a done pulse.

Test Plan:
- Reset; LOGIN acc 2003 pin 3 -> rsp at T+12, OK, rsp_balance 500, session_active=1.
- WITHDRAW 200 then 400 -> OK bal 300, then INSUF_FUNDS bal 300.
- TRANSFER 100 to 2007 -> OK bal 200; TRANSFER to 2003 -> BAD_DEST; to 2042 -> BAD_DEST.
- Cfg entry 5 bal 65500 (no session); LOGIN 2005 pin 5, DEPOSIT 100 -> OVERFLOW bal 65500; DEPOSIT 35 -> OK 65535.
- LOGIN 2001 with pin 9 three times -> BAD_AUTH x3, locked_mask[1]=1; pin 1 -> LOCKED; cfg write idx 1 -> unlocked, LOGIN OK.
- Login, idle 1000 cycles -> TIMEOUT pulse, session_active=0; BALANCE -> NO_SESSION; op 7 -> ILLEGAL.
